sram_bus_bridge: RTL and testbench
==================================

Name: sram_bus_bridge

Overview:
- Parametrised successor to the fixed-width sreg + bus_fsm pair in the CPLD.
- Loads an SRAM address serially from the AVR (avr_si) and runs timed SRAM read/write cycles on AVR oe/we strobes.
- Adds configurable data/address width, wait states and address auto-increment for burst transfers.
- Sits between the AVR parallel/serial pins and the external SRAM. Tri-states live in the top level; this block exposes split in/out/oe buses.

Parameters:
- DATA_W, 8, data bus width.
- ADDR_W, 21, SRAM address width.
- WAIT_CYCLES, 1, extra cycles the SRAM strobe is held low (access pulse = WAIT_CYCLES+1 cycles).
- AUTO_INC, 1, post-access address increment enable: 1 = increment, 0 = hold.

Ports:
- avr_clk  in  1  system clock; all logic on the rising edge.
- avr_reset  in  1  synchronous, active-high reset.
- avr_si  in  1  serial address bit, MSB first.
- avr_sreg_en  in  1  0 = shift address, 1 = address locked, bus enabled.
- avr_oe  in  1  active-low read request (AVR side).
- avr_we  in  1  active-low write request (AVR side).
- avr_data_in  in  DATA_W  write data from AVR.
- avr_data_out  out  DATA_W  read data to AVR.
- avr_data_oe  out  1  drive enable for the AVR data pins.
- sram_addr  out  ADDR_W  SRAM address (address register).
- sram_data_in  in  DATA_W  data from SRAM.
- sram_data_out  out  DATA_W  data to SRAM.
- sram_data_oe  out  1  drive enable for the SRAM data pins.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
- busy  out  1  high in any state except IDLE and RD_DONE.

Behaviour:
- Reset values (applied on the first rising edge with avr_reset=1, including mid-operation):
  - state=IDLE, sram_addr=0, data buffer=0.
  - avr_data_out=0; avr_data_oe=0 and sram_data_oe=0.
  - sram_ce_n, sram_oe_n, sram_we_n all 1; busy=0.
- Address shift: in IDLE with avr_sreg_en=0, each cycle sram_addr <= {sram_addr[ADDR_W-2:0], avr_si}. No shifting in any other state.
- Request detect: avr_oe and avr_we are registered once; a request is a falling edge (prev=1, now=0) sampled in IDLE with avr_sreg_en=1.
  - Both edges in the same cycle: the write wins and the read is dropped.
  - Edges in any non-IDLE state are ignored, not queued.
  - With avr_sreg_en=0, requests are ignored.
- States: IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
- Read path:
  - IDLE -> RD_ACC: ce_n=0, oe_n=0 for WAIT_CYCLES+1 cycles.
  - On the last RD_ACC cycle, capture sram_data_in into the buffer; then go to RD_DONE.
  - RD_DONE: strobes high; avr_data_out=buffer; avr_data_oe=1. Stay until avr_oe=1, then go to IDLE.
  - Latency: avr_data_oe rises WAIT_CYCLES+2 cycles after the cycle in which the edge is detected.
- Write path:
  - At request, capture avr_data_in into the buffer.
  - WR_SETUP (1 cycle): ce_n=0, sram_data_oe=1, we_n=1.
  - WR_PULSE (WAIT_CYCLES+1 cycles): we_n=0.
  - WR_HOLD (1 cycle): we_n=1, data still driven, ce_n=0.
  - Then IDLE.
- Auto-increment: when AUTO_INC=1, on leaving RD_ACC or WR_HOLD, sram_addr <= sram_addr+1, modulo 2^ADDR_W (all-ones wraps to 0).
- A wait counter of width clog2(WAIT_CYCLES+1) reloads on every state entry.
- If avr_sreg_en drops mid-access, the access still completes; shifting resumes in IDLE only.
- Invariants, asserted in the bench:
  - sram_data_oe=1 never coincides with sram_oe_n=0.
  - avr_data_oe=1 never coincides with a write state.
  - sram_we_n and sram_oe_n are never both 0.

Decomposition:
- Package sram_bridge_pkg holds:
  - the state enum;
  - default widths;
  - the request-type encoding (REQ_NONE, REQ_RD, REQ_WR).
- One sub-module, addr_sreg:
  - parametrised ADDR_W shift register with load-shift and increment inputs;
  - wraps modulo 2^ADDR_W.
- The FSM and buffer stay in sram_bus_bridge.

Test Plan:
- Shift 15 bits 1,0,0,1,1,0,0,1,1,0,0,1,1,1,1 with avr_sreg_en=0 -> sram_addr=0x04CCF.
- sreg_en=1, sram_data_in=0xAA, avr_oe falls (WAIT_CYCLES=1):
  - sram_oe_n low exactly 2 cycles;
  - avr_data_out=0xAA with avr_data_oe=1 three cycles after the detected edge;
  - sram_addr becomes 0x04CD0.
- avr_oe high then low, sram_data_in=0xBB -> second read returns 0xBB at 0x04CD0; address becomes 0x04CD1.
- avr_data_in=0xEE, avr_we falls:
  - sram_data_out=0xEE with sram_data_oe=1 for 4 cycles;
  - sram_we_n low cycles 2-3 only;
  - sram_oe_n stays 1.
- sram_addr=0x1FFFFF, read -> sram_addr wraps to 0x000000. Repeat with AUTO_INC=0 -> address unchanged.
- avr_oe and avr_we fall in the same cycle -> only the write is performed. Assert avr_reset during WR_PULSE -> next edge: all strobes 1, both oe 0, sram_addr=0, state IDLE.

Source files
------------

// File: rtl/sram_bridge_pkg.sv
// ---------------------------------------------------------------------------
// sram_bridge_pkg
// Shared types and default sizes for the AVR-to-SRAM bus bridge.
//   bridge_state_e : bus sequencer states
//   req_e          : request decoded from the AVR strobes in IDLE
//   DEFAULT_*      : default data/address width and wait-state count
// ---------------------------------------------------------------------------
package sram_bridge_pkg;

    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_ADDR_W      = 21;
    localparam int DEFAULT_WAIT_CYCLES = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } bridge_state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_RD,
        REQ_WR
    } req_e;

endpackage

// File: rtl/sram_bus_bridge_addr_sreg.sv
// ---------------------------------------------------------------------------
// addr_sreg
// SRAM address register: serial load (MSB first) or post-access increment.
// Increment wraps modulo 2^ADDR_W. Shift has priority over increment.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears the address
//   shift_en : shift si in at the LSB
//   si       : serial address bit
//   inc_en   : add one to the address
//   addr     : current address
// ---------------------------------------------------------------------------
module addr_sreg
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              si,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] addr
);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else if (shift_en) begin
            addr <= {addr[ADDR_W-2:0], si};
        end else if (inc_en) begin
            addr <= addr + ADDR_W'(1);   // all-ones rolls over to zero
        end
    end

endmodule

// File: rtl/sram_bus_bridge.sv
// ---------------------------------------------------------------------------
// sram_bus_bridge
// Bridges the AVR parallel/serial pins to an external asynchronous SRAM.
// The address is shifted in serially while avr_sreg_en=0; with the address
// locked (avr_sreg_en=1) a falling edge on avr_oe / avr_we starts a timed
// SRAM read / write cycle. Tri-state buffers live in the level above; this
// block exposes split in/out/oe buses.
//
// Ports:
//   avr_clk, avr_reset        : clock, synchronous active-high reset
//   avr_si, avr_sreg_en       : serial address bit, shift(0)/lock(1) select
//   avr_oe, avr_we            : active-low AVR read / write requests
//   avr_data_in/out, _oe      : AVR data bus halves and drive enable
//   sram_addr                 : SRAM address
//   sram_data_in/out, _oe     : SRAM data bus halves and drive enable
//   sram_ce_n/oe_n/we_n       : active-low SRAM strobes
//   busy                      : access in progress (not IDLE, not RD_DONE)
// ---------------------------------------------------------------------------
module sram_bus_bridge
    import sram_bridge_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int AUTO_INC    = 1
) (
    input  logic              avr_clk,
    input  logic              avr_reset,
    input  logic              avr_si,
    input  logic              avr_sreg_en,
    input  logic              avr_oe,
    input  logic              avr_we,
    input  logic [DATA_W-1:0] avr_data_in,
    output logic [DATA_W-1:0] avr_data_out,
    output logic              avr_data_oe,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic [DATA_W-1:0] sram_data_out,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy
);

    // Counter must be at least one bit wide even with zero wait states.
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    bridge_state_e     state, state_next;
    req_e              req;
    logic [CNT_W-1:0]  wait_cnt;
    logic              acc_last;
    logic [DATA_W-1:0] buffer;
    logic              oe_q, we_q;
    logic              shift_en, inc_en;

    // Previous strobe levels for edge detection. They simply follow the pins,
    // so no reset is needed: the state register is what reset forces idle.
    always_ff @(posedge avr_clk) begin
        oe_q <= avr_oe;
        we_q <= avr_we;
    end

    // A request is only taken in IDLE with the address locked; a simultaneous
    // read and write edge resolves to the write.
    always_comb begin
        req = REQ_NONE;
        if (state == IDLE && avr_sreg_en) begin
            if (we_q && !avr_we) begin
                req = REQ_WR;
            end else if (oe_q && !avr_oe) begin
                req = REQ_RD;
            end
        end
    end

    // Last cycle of a timed strobe (RD_ACC / WR_PULSE).
    assign acc_last = (wait_cnt == '0);

    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reloaded on every state change, counts down while a state is held.
    always_ff @(posedge avr_clk) begin
        if (avr_reset || state_next != state) begin
            wait_cnt <= CNT_LOAD;
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // NOTE: the data buffer is a single register, not a memory array, so it
    // takes a reset and the AVR never sees stale data after reset.
    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            buffer <= '0;
        end else if (req == REQ_WR) begin
            buffer <= avr_data_in;
        end else if (state == RD_ACC && acc_last) begin
            buffer <= sram_data_in;
        end
    end

    assign shift_en = (state == IDLE) && !avr_sreg_en;
    assign inc_en   = (AUTO_INC != 0) &&
                      ((state == RD_ACC && acc_last) || state == WR_HOLD);

    addr_sreg #(
        .ADDR_W (ADDR_W)
    ) u_addr_sreg (
        .clk      (avr_clk),
        .reset    (avr_reset),
        .shift_en (shift_en),
        .si       (avr_si),
        .inc_en   (inc_en),
        .addr     (sram_addr)
    );

    assign sram_data_out = buffer;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_data_oe = 1'b0;
        avr_data_oe  = 1'b0;
        avr_data_out = '0;
        busy         = 1'b1;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req == REQ_WR) begin
                    state_next = WR_SETUP;
                end else if (req == REQ_RD) begin
                    state_next = RD_ACC;
                end
            end
            RD_ACC: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                if (acc_last) begin
                    state_next = RD_DONE;
                end
            end
            RD_DONE: begin
                busy         = 1'b0;
                avr_data_oe  = 1'b1;
                avr_data_out = buffer;
                if (avr_oe) begin
                    state_next = IDLE;
                end
            end
            WR_SETUP: begin
                sram_ce_n    = 1'b0;
                sram_data_oe = 1'b1;
                state_next   = WR_PULSE;
            end
            WR_PULSE: begin
                sram_ce_n    = 1'b0;
                sram_data_oe = 1'b1;
                sram_we_n    = 1'b0;
                if (acc_last) begin
                    state_next = WR_HOLD;
                end
            end
            WR_HOLD: begin
                sram_ce_n    = 1'b0;
                sram_data_oe = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_bridge
// Directed bench for sram_bus_bridge. Two instances share all inputs: dut
// increments the address after each access, dut_hold does not. Expected
// read/write data go into queues when a request is driven and are popped
// when the bridge presents the data.
// ---------------------------------------------------------------------------
module tb_sram_bus_bridge;
    import sram_bridge_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 21;
    localparam int WAIT   = 1;

    logic              clk;
    logic              reset;
    logic              avr_si;
    logic              avr_sreg_en;
    logic              avr_oe;
    logic              avr_we;
    logic [DATA_W-1:0] avr_data_in;
    logic [DATA_W-1:0] sram_data_in;

    logic [DATA_W-1:0] avr_data_out,  h_avr_data_out;
    logic              avr_data_oe,   h_avr_data_oe;
    logic [ADDR_W-1:0] sram_addr,     h_sram_addr;
    logic [DATA_W-1:0] sram_data_out, h_sram_data_out;
    logic              sram_data_oe,  h_sram_data_oe;
    logic              sram_ce_n,     h_sram_ce_n;
    logic              sram_oe_n,     h_sram_oe_n;
    logic              sram_we_n,     h_sram_we_n;
    logic              busy,          h_busy;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] wr_q[$];

    sram_bus_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT), .AUTO_INC(1)
    ) dut (
        .avr_clk      (clk),
        .avr_reset    (reset),
        .avr_si       (avr_si),
        .avr_sreg_en  (avr_sreg_en),
        .avr_oe       (avr_oe),
        .avr_we       (avr_we),
        .avr_data_in  (avr_data_in),
        .avr_data_out (avr_data_out),
        .avr_data_oe  (avr_data_oe),
        .sram_addr    (sram_addr),
        .sram_data_in (sram_data_in),
        .sram_data_out(sram_data_out),
        .sram_data_oe (sram_data_oe),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .busy         (busy)
    );

    sram_bus_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT), .AUTO_INC(0)
    ) dut_hold (
        .avr_clk      (clk),
        .avr_reset    (reset),
        .avr_si       (avr_si),
        .avr_sreg_en  (avr_sreg_en),
        .avr_oe       (avr_oe),
        .avr_we       (avr_we),
        .avr_data_in  (avr_data_in),
        .avr_data_out (h_avr_data_out),
        .avr_data_oe  (h_avr_data_oe),
        .sram_addr    (h_sram_addr),
        .sram_data_in (sram_data_in),
        .sram_data_out(h_sram_data_out),
        .sram_data_oe (h_sram_data_oe),
        .sram_ce_n    (h_sram_ce_n),
        .sram_oe_n    (h_sram_oe_n),
        .sram_we_n    (h_sram_we_n),
        .busy         (h_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock, then sample 1 time unit after the edge and check invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        check("inv_dataoe_vs_oen", {31'b0, sram_data_oe & ~sram_oe_n}, 32'd0);
        check("inv_avroe_in_write",
              {31'b0, avr_data_oe & (dut.state inside {WR_SETUP, WR_PULSE, WR_HOLD})},
              32'd0);
        check("inv_wen_and_oen", {31'b0, ~sram_we_n & ~sram_oe_n}, 32'd0);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        avr_sreg_en = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            avr_si = bits[i];
            tick();
        end
        avr_sreg_en = 1'b1;
    endtask

    task automatic do_read(input logic [DATA_W-1:0] data,
                           input logic [ADDR_W-1:0] exp_addr,
                           input logic [ADDR_W-1:0] exp_hold_addr);
        int lat;
        int oe_low;
        logic [DATA_W-1:0] exp_d;
        lat    = 0;
        oe_low = 0;
        sram_data_in = data;
        rd_q.push_back(data);
        avr_oe = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            if (!sram_oe_n) oe_low++;
            if (avr_data_oe) lat = i;
        end
        check("rd_latency", lat, WAIT + 2);
        check("rd_oen_low_cycles", oe_low, WAIT + 1);
        exp_d = rd_q.pop_front();
        check("rd_data", avr_data_out, exp_d);
        check("rd_busy_done", busy, 1'b0);
        check("rd_addr", sram_addr, exp_addr);
        check("rd_addr_hold", h_sram_addr, exp_hold_addr);
        avr_oe = 1'b1;
        tick();
        check("rd_release_oe", avr_data_oe, 1'b0);
    endtask

    task automatic do_write(input logic [DATA_W-1:0] data,
                            input logic [ADDR_W-1:0] exp_addr);
        logic [5:0] doe_pat, wen_pat, oen_pat;
        logic [DATA_W-1:0] exp_d;
        logic got;
        doe_pat = '0;
        wen_pat = '0;
        oen_pat = '0;
        exp_d   = '0;
        got     = 1'b0;
        avr_data_in = data;
        wr_q.push_back(data);
        avr_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) begin
                // Data must have been captured at the request.
                avr_we      = 1'b1;
                avr_oe      = 1'b1;
                avr_data_in = ~data;
            end
            doe_pat[i] = sram_data_oe;
            wen_pat[i] = ~sram_we_n;
            oen_pat[i] = ~sram_oe_n | avr_data_oe;
            if (sram_data_oe) begin
                if (!got) begin
                    got   = 1'b1;
                    exp_d = wr_q.pop_front();
                end
                check("wr_data", sram_data_out, exp_d);
            end
        end
        check("wr_seen", got, 1'b1);
        check("wr_data_oe_pattern", doe_pat, 6'b001111);
        check("wr_we_n_low_pattern", wen_pat, 6'b000110);
        check("wr_no_read_activity", oen_pat, 6'b000000);
        check("wr_addr", sram_addr, exp_addr);
    endtask

    initial begin
        reset        = 1'b1;
        avr_si       = 1'b0;
        avr_sreg_en  = 1'b0;
        avr_oe       = 1'b1;
        avr_we       = 1'b1;
        avr_data_in  = '0;
        sram_data_in = '0;
        tick();
        tick();
        check("rst_addr", sram_addr, 0);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_oes", {avr_data_oe, sram_data_oe}, 2'b00);
        check("rst_avr_data", avr_data_out, 0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;

        // Serial address load, MSB first.
        shift_bits(32'b100110011001111, 15);
        check("shift_addr", sram_addr, 21'h04CCF);

        do_read(8'hAA, 21'h04CD0, 21'h04CCF);
        do_read(8'hBB, 21'h04CD1, 21'h04CCF);
        do_write(8'hEE, 21'h04CD2);
        check("wr_addr_hold", h_sram_addr, 21'h04CCF);

        // Address wrap with increment, no change without it.
        shift_bits(32'h001F_FFFF, 21);
        check("wrap_pre", sram_addr, 21'h1FFFFF);
        do_read(8'h5A, 21'h000000, 21'h1FFFFF);

        // Simultaneous read and write edges: only the write happens.
        sram_data_in = 8'h99;
        avr_oe = 1'b0;
        do_write(8'h3C, 21'h000001);
        check("both_rd_queue_empty", rd_q.size(), 0);
        check("both_hold_addr", h_sram_addr, 21'h1FFFFF);

        // Reset during WR_PULSE.
        avr_data_in = 8'h77;
        avr_we = 1'b0;
        tick();
        tick();
        check("mid_wr_we_low", sram_we_n, 1'b0);
        reset  = 1'b1;
        avr_we = 1'b1;
        tick();
        check("midrst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("midrst_oes", {avr_data_oe, sram_data_oe}, 2'b00);
        check("midrst_addr", sram_addr, 0);
        check("midrst_state", dut.state, IDLE);
        check("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
